apb_regfile_bridge: RTL

APB slave front-end that sits directly upstream of the generated register file. It converts APB setup/access transactions into the register file's single write port (wr_en_0/wr_addr_0/wr_data_0/wr_be_0) and single read port (rd_addr_0 -> rd_data_0). It registers all register-file controls, inserts a fixed number of wait states, and flags out-of-range or misaligned accesses with pslverr.

---
 rtl/apb_regfile_bridge.sv | 126 ++++++++++++
 1 files changed

// File: rtl/apb_regfile_bridge.sv
// APB slave front-end for the generated register file: one registered write port,
// one registered read address, fixed read wait states and decode-error responses.
module apb_regfile_bridge #(
   parameter int                    ADDR_WIDTH  = 8,
   parameter int                    DATA_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] MAX_ADDR    = 'h04,
   parameter bit                    ALIGN_CHECK = 1'b1,
   parameter int                    RD_WAIT     = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic                    pready,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pslverr,
   output logic                    wr_en_0,
   output logic [ADDR_WIDTH-1:0]   wr_addr_0,
   output logic [DATA_WIDTH-1:0]   wr_data_0,
   output logic [DATA_WIDTH/8-1:0] wr_be_0,
   output logic [ADDR_WIDTH-1:0]   rd_addr_0,
   input  logic [DATA_WIDTH-1:0]   rd_data_0
);

   localparam int STRB_W = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, WRITE, RWAIT, RESP} state_t;

   state_t                  state_q, state_d;
   logic [1:0]              cnt_q, cnt_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
   logic                    wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
   logic [STRB_W-1:0]       wr_be_q, wr_be_d;
   logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
   logic                    setup_err;

   assign setup_err = (paddr > MAX_ADDR) | (ALIGN_CHECK & (paddr[1:0] != 2'b00));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      prdata_d  = prdata_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_be_d   = wr_be_q;
      rd_addr_d = rd_addr_q;
      unique case (state_q)
         IDLE: begin
            // Only a genuine setup phase starts a transfer; psel+penable here is ignored.
            if (psel && !penable) begin
               err_d = setup_err;
               if (setup_err) begin
                  prdata_d = '0;
                  state_d  = RESP;
               end else if (pwrite) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = paddr;
                  wr_data_d = pwdata;
                  wr_be_d   = pstrb;
                  state_d   = WRITE;
               end else begin
                  rd_addr_d = paddr;
                  cnt_d     = 2'(RD_WAIT);
                  state_d   = RWAIT;
               end
            end
         end
         WRITE: state_d = psel ? RESP : IDLE;
         RWAIT: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (cnt_q != 2'd0) begin
               cnt_d = cnt_q - 2'd1;
            end else begin
               prdata_d = rd_data_0;
               state_d  = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         prdata_q  <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_be_q   <= '0;
         rd_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         prdata_q  <= prdata_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_be_q   <= wr_be_d;
         rd_addr_q <= rd_addr_d;
      end
   end

   assign pready    = (state_q == RESP);
   assign pslverr   = (state_q == RESP) & err_q;
   assign prdata    = prdata_q;
   assign wr_en_0   = wr_en_q;
   assign wr_addr_0 = wr_addr_q;
   assign wr_data_0 = wr_data_q;
   assign wr_be_0   = wr_be_q;
   assign rd_addr_0 = rd_addr_q;

endmodule
